// File: rtl/router_pkg.sv
// Shared ring-router definitions.
//   ROUTER_DATA_WIDTH : default packet width
//   ROUTER_DIR_BIT    : default index of the direction bit inside a packet
//   DIR_CW / DIR_CCW  : direction bit encoding
//   clog2()           : ceil(log2(v)), usable in parameter expressions
package router_pkg;
  localparam int ROUTER_DATA_WIDTH = 64;
  localparam int ROUTER_DIR_BIT    = 62;
  localparam logic DIR_CW  = 1'b0;
  localparam logic DIR_CCW = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/vc_fifo.sv
// One virtual-channel FIFO, DEPTH x DATA_WIDTH.
//   clk, rst      : clock, async active-high reset (pointers/count only)
//   push, wdata   : write request; ignored when full
//   pop           : read request; ignored when empty
//   rdata         : current head entry (raw storage, caller masks when empty)
//   full, empty   : status
//   count         : occupancy 0..DEPTH
module vc_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty,
  output logic [CNT_W-1:0]      count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: every consumer masks it with empty.
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/pe_input_vc.sv
// PE input port with NUM_VC virtual-channel FIFOs.
//   clk, rst            : clock, async active-high reset
//   pesi, pedi, vc_sel  : PE send valid, packet, target VC
//   peri                : ready = target VC exists and is not full
//   request_cw/ccw      : per-VC head request, chosen by head[DIR_BIT]
//   grant_cw/ccw        : per-VC grants; only a grant matching the raised
//                         request pops the head
//   data_out            : per-VC head packet (0 when empty), VC v at
//                         [v*DATA_WIDTH +: DATA_WIDTH]
//   vc_count            : per-VC occupancy, VC v at [v*CNT_W +: CNT_W]
module pe_input_vc
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = ROUTER_DATA_WIDTH,
  parameter int NUM_VC     = 2,
  parameter int DEPTH      = 4,
  parameter int DIR_BIT    = ROUTER_DIR_BIT,
  parameter int VC_W       = (NUM_VC > 1) ? clog2(NUM_VC) : 1,
  parameter int CNT_W      = clog2(DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pesi,
  input  logic [DATA_WIDTH-1:0]        pedi,
  input  logic [VC_W-1:0]              vc_sel,
  output logic                         peri,
  output logic [NUM_VC-1:0]            request_cw,
  output logic [NUM_VC-1:0]            request_ccw,
  input  logic [NUM_VC-1:0]            grant_cw,
  input  logic [NUM_VC-1:0]            grant_ccw,
  output logic [NUM_VC*DATA_WIDTH-1:0] data_out,
  output logic [NUM_VC*CNT_W-1:0]      vc_count
);
  logic [NUM_VC-1:0]                 full, empty, push, pop;
  logic [NUM_VC-1:0][DATA_WIDTH-1:0] head, head_q;
  logic [NUM_VC-1:0][CNT_W-1:0]      cnt;

  // Out-of-range vc_sel matches no lane, so peri stays 0.
  always_comb begin
    peri = 1'b0;
    for (int v = 0; v < NUM_VC; v++)
      if (vc_sel == VC_W'(v)) peri = !full[v];
  end

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    assign push[v] = pesi && peri && (vc_sel == VC_W'(v));

    vc_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .CNT_W      (CNT_W)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[v]),
      .wdata (pedi),
      .pop   (pop[v]),
      .rdata (head[v]),
      .full  (full[v]),
      .empty (empty[v]),
      .count (cnt[v])
    );

    // Requests and head come from registered FIFO state only, so an async
    // reset clears them immediately through empty.
    assign head_q[v]      = empty[v] ? '0 : head[v];
    assign request_cw[v]  = !empty[v] && (head[v][DIR_BIT] == DIR_CW);
    assign request_ccw[v] = !empty[v] && (head[v][DIR_BIT] == DIR_CCW);
    assign pop[v] = (grant_cw[v] && request_cw[v]) ||
                    (grant_ccw[v] && request_ccw[v]);
  end

  assign data_out = head_q;
  assign vc_count = cnt;
endmodule

// File: tb/tb_pe_input_vc.sv
// Directed test for pe_input_vc (DATA_WIDTH=64, NUM_VC=2, DEPTH=4).
module tb_pe_input_vc;
  logic         clk = 1'b0;
  logic         rst;
  logic         pesi;
  logic [63:0]  pedi;
  logic [0:0]   vc_sel;
  logic         peri;
  logic [1:0]   request_cw, request_ccw, grant_cw, grant_ccw;
  logic [127:0] data_out;
  logic [5:0]   vc_count;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [63:0] CCW = 64'h4000_0000_0000_0000;

  pe_input_vc dut (
    .clk         (clk),
    .rst         (rst),
    .pesi        (pesi),
    .pedi        (pedi),
    .vc_sel      (vc_sel),
    .peri        (peri),
    .request_cw  (request_cw),
    .request_ccw (request_ccw),
    .grant_cw    (grant_cw),
    .grant_ccw   (grant_ccw),
    .data_out    (data_out),
    .vc_count    (vc_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Inputs change 1ns after the rising edge; checks follow in the same window.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic vc, input logic [63:0] d);
    pesi = 1'b1; vc_sel = vc; pedi = d;
    tick();
    pesi = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pesi = 1'b0; pedi = '0; vc_sel = '0;
    grant_cw = '0; grant_ccw = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_peri", peri, 1'b1);
    chk("rst_req_cw", request_cw, 2'b00);
    chk("rst_req_ccw", request_ccw, 2'b00);
    chk("rst_data", data_out, '0);
    chk("rst_count", vc_count, 6'd0);

    // Single cw packet on VC0, then granted.
    push(1'b0, 64'h0);
    chk("cw_req", request_cw, 2'b01);
    chk("cw_req_ccw", request_ccw, 2'b00);
    chk("cw_data", data_out[63:0], 64'h0);
    chk("cw_count", vc_count, 6'b000_001);
    grant_cw = 2'b01; tick(); grant_cw = '0;
    chk("cw_pop_req", request_cw, 2'b00);
    chk("cw_pop_count", vc_count, 6'd0);

    // ccw packet on VC1; a cw grant must not pop it.
    push(1'b1, CCW | 64'hAA);
    chk("ccw_req", request_ccw, 2'b10);
    chk("ccw_req_cw", request_cw, 2'b00);
    chk("ccw_data", data_out[127:64], 64'h4000_0000_0000_00AA);
    grant_cw = 2'b10; tick(); grant_cw = '0;
    chk("mismatch_req", request_ccw, 2'b10);
    chk("mismatch_count", vc_count, 6'b001_000);
    grant_ccw = 2'b10; tick(); grant_ccw = '0;
    chk("ccw_pop_count", vc_count, 6'd0);

    // Fill VC0, check per-VC ready, drop a 5th beat, drain in order.
    push(1'b0, 64'h11);
    push(1'b0, CCW | 64'h22);
    push(1'b0, 64'h33);
    push(1'b0, 64'h44);
    vc_sel = 1'b0; #1;
    chk("full_peri0", peri, 1'b0);
    vc_sel = 1'b1; #1;
    chk("full_peri1", peri, 1'b1);
    push(1'b0, 64'h55);
    chk("drop_count", vc_count, 6'b000_100);
    chk("drain0_data", data_out[63:0], 64'h11);
    chk("drain0_req", request_cw, 2'b01);
    grant_cw = 2'b01; grant_ccw = 2'b01;
    tick();
    chk("drain1_data", data_out[63:0], 64'h4000_0000_0000_0022);
    chk("drain1_req", request_ccw, 2'b01);
    tick();
    chk("drain2_data", data_out[63:0], 64'h33);
    tick();
    chk("drain3_data", data_out[63:0], 64'h44);
    tick();
    grant_cw = '0; grant_ccw = '0;
    chk("drain_req_cw", request_cw, 2'b00);
    chk("drain_req_ccw", request_ccw, 2'b00);
    chk("drain_count", vc_count, 6'd0);

    // Simultaneous push+pop at count 2, then at full.
    push(1'b0, 64'hA1);
    push(1'b0, 64'hA2);
    pesi = 1'b1; vc_sel = 1'b0; pedi = 64'hA3; grant_cw = 2'b01;
    tick();
    pesi = 1'b0; grant_cw = '0;
    chk("pp2_count", vc_count, 6'b000_010);
    chk("pp2_head", data_out[63:0], 64'hA2);
    push(1'b0, 64'hA4);
    push(1'b0, 64'hA5);
    chk("pp4_count", vc_count, 6'b000_100);
    pesi = 1'b1; vc_sel = 1'b0; pedi = 64'hA6; grant_cw = 2'b01;
    #1;
    chk("pp4_peri", peri, 1'b0);
    tick();
    pesi = 1'b0; grant_cw = '0;
    chk("pp4_pop_count", vc_count, 6'b000_011);
    chk("pp4_head", data_out[63:0], 64'hA3);
    chk("pp4_ready_again", peri, 1'b1);
    grant_cw = 2'b01;
    tick();
    chk("pp_d1", data_out[63:0], 64'hA4);
    tick();
    chk("pp_d2", data_out[63:0], 64'hA5);
    tick();
    grant_cw = '0;
    chk("pp_empty", vc_count, 6'd0);

    // Async reset mid-stream with 3 packets in each VC.
    for (int i = 0; i < 3; i++) begin
      push(1'b0, 64'h100 + 64'(i));
      push(1'b1, CCW | (64'h200 + 64'(i)));
    end
    chk("pre_rst_count", vc_count, 6'b011_011);
    chk("pre_rst_cw", request_cw, 2'b01);
    chk("pre_rst_ccw", request_ccw, 2'b10);
    #1 rst = 1'b1;
    #1;
    chk("arst_req_cw", request_cw, 2'b00);
    chk("arst_req_ccw", request_ccw, 2'b00);
    chk("arst_count", vc_count, 6'd0);
    chk("arst_data", data_out, '0);
    chk("arst_peri", peri, 1'b1);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_count", vc_count, 6'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
